// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line/clock constants.
// The transmit side is expected to import this package as well.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int DEFAULT_BAUD      = 9600;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_tick_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every TICK_DIV clocks.
// While clear is high the divider sits at 0, so the tick phase restarts
// from the moment clear drops.
module uart_baud_tick #(
    parameter int TICK_DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_reg;

    // Free-running divider, held at zero while cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else if (clear || div_cnt_reg == CNT_LAST) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + CNT_W'(1);
        end
    end

    assign tick = !clear && (div_cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF input synchronizer, 16x oversampled bit timing,
// LSB-first shift register, one-clk done/framing-error strobes and a
// break state that swallows a held-low line instead of decoding 0x00s.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TCNT_W   = $clog2(OVERSAMPLE);
    localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);

    logic              rx_meta_reg;
    logic              rx_s;
    logic              tick;
    logic              baud_clear;
    uart_state_t       state_reg;
    logic [TCNT_W-1:0] tick_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;
        end
    end

    // Tick phase realigns to each start edge because the divider is held in IDLE.
    assign baud_clear = (state_reg == IDLE);

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    // Receive FSM with registered data, strobes and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_done      <= 1'b0;
            frame_err    <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                tick_cnt_reg <= tick_cnt_reg + TCNT_W'(1);
            end
            case (state_reg)
                IDLE: begin
                    tick_cnt_reg <= '0;
                    rx_busy      <= 1'b0;
                    if (!rx_s) begin
                        state_reg <= START;
                        rx_busy   <= 1'b1;
                    end
                end
                START: begin
                    // Mid start bit: a line that is high again was only a glitch.
                    if (tick && tick_cnt_reg == TCNT_MID) begin
                        tick_cnt_reg <= '0;
                        if (!rx_s) begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                            rx_busy   <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick && tick_cnt_reg == TCNT_LAST) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg    <= STOP;
                            tick_cnt_reg <= '0;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Decided mid stop bit, so IDLE is back while the line is still high.
                    if (tick && tick_cnt_reg == TCNT_LAST) begin
                        tick_cnt_reg <= '0;
                        if (rx_s) begin
                            rx_data   <= shift_reg;
                            rx_done   <= 1'b1;
                            state_reg <= IDLE;
                            rx_busy   <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    tick_cnt_reg <= '0;
                    if (rx_s) begin
                        state_reg <= IDLE;
                        rx_busy   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core. The clock is scaled down so that one tick
// is 8 clocks while the bit times stay at the real 9600-baud values.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int      CLK_FREQ = 1_228_800;
    localparam realtime CLK_HALF = 1.0e9 / (2.0 * CLK_FREQ);
    localparam int      BIT_NS   = 104166;
    localparam int      BIT_FAST = 101041;
    localparam int      BIT_SLOW = 107291;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int   total = 0;
    int   bad   = 0;

    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   both_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] data_q[$];
    logic prev_done = 1'b0;
    time  fall_t = 0;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (9600),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #(CLK_HALF) clk = ~clk;

    // Observe strobes on the inactive edge.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            last_data = rx_data;
            data_q.push_back(rx_data);
        end
        if (frame_err) err_cnt++;
        if (rx_done && frame_err) both_cnt++;
        if (prev_done && !rx_done) fall_t = $time;
        prev_done = rx_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs, input logic [31:0] lo, input logic [31:0] hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected range %0d..%0d", tag, obs, lo, hi);
        end
        $display("check %-16s observed=%0d expected range %0d..%0d", tag, obs, lo, hi);
    endtask

    // Drive one 8N1 frame; the line is left at stop_lvl afterwards.
    task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_lvl);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_lvl;
        #(bit_ns);
    endtask

    initial begin
        int  d0;
        int  e0;
        int  q0;
        time t0;

        // Reset state
        #1000;
        check("rst_data", rx_data, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        rst = 1'b0;
        #20000;

        // Single 0x11 frame with latency window
        d0 = done_cnt; e0 = err_cnt;
        t0 = $time;
        send_byte(8'h11, BIT_NS, 1'b1);
        #20000;
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_data", rx_data, 8'h11);
        check("t1_err_cnt", err_cnt - e0, 0);
        check_range("t1_fall_ns", 32'(fall_t - t0), 989000, 996000);

        // Thirteen frames with 200 us gaps
        d0 = done_cnt; e0 = err_cnt;
        for (int k = 0; k < 13; k++) begin
            send_byte(8'h11, BIT_NS, 1'b1);
            #200000;
            check("t2_data", last_data, 8'h11);
        end
        check("t2_done_cnt", done_cnt - d0, 13);
        check("t2_err_cnt", err_cnt - e0, 0);

        // Back-to-back frames, no idle between stop and next start
        d0 = done_cnt; q0 = data_q.size();
        send_byte(8'h55, BIT_NS, 1'b1);
        send_byte(8'hAA, BIT_NS, 1'b1);
        #50000;
        check("t3_done_cnt", done_cnt - d0, 2);
        check("t3_first", data_q[q0], 8'h55);
        check("t3_second", data_q[q0+1], 8'hAA);

        // 2 us glitch on the idle line
        d0 = done_cnt; e0 = err_cnt;
        rx = 1'b0;
        #2000;
        rx = 1'b1;
        #8000;
        check("t4_busy_high", rx_busy, 1'b1);
        #50000;
        check("t4_busy_low", rx_busy, 1'b0);
        #100000;
        check("t4_done_cnt", done_cnt - d0, 0);
        check("t4_err_cnt", err_cnt - e0, 0);

        // Framing error, held-low break, then a good frame
        rst = 1'b1;
        #200;
        check("t5_rst_data", rx_data, 8'h00);
        rst = 1'b0;
        #20000;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h3C, BIT_NS, 1'b0);
        #500000;
        check("t5_err_cnt", err_cnt - e0, 1);
        check("t5_no_strobe", done_cnt - d0, 0);
        check("t5_data_kept", rx_data, 8'h00);
        check("t5_busy_break", rx_busy, 1'b1);
        rx = 1'b1;
        #200000;
        check("t5_busy_idle", rx_busy, 1'b0);
        send_byte(8'hA5, BIT_NS, 1'b1);
        #20000;
        check("t5_done_cnt", done_cnt - d0, 1);
        check("t5_data", rx_data, 8'hA5);
        check("t5_err_total", err_cnt - e0, 1);

        // Reset in the middle of bit 4, then a fresh frame
        d0 = done_cnt; e0 = err_cnt;
        rx = 1'b0;
        #(BIT_NS);
        rx = 1'b1;
        #(4 * BIT_NS + BIT_NS / 2);
        rst = 1'b1;
        #50;
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_done", rx_done, 1'b0);
        check("t6_rst_err", frame_err, 1'b0);
        check("t6_rst_busy", rx_busy, 1'b0);
        #50;
        rst = 1'b0;
        #1200000;
        check("t6_aborted", done_cnt - d0, 0);
        send_byte(8'hC3, BIT_NS, 1'b1);
        #20000;
        check("t6_done_cnt", done_cnt - d0, 1);
        check("t6_data", rx_data, 8'hC3);
        check("t6_err_cnt", err_cnt - e0, 0);

        // Line rate +3% and -3%
        d0 = done_cnt;
        send_byte(8'h11, BIT_FAST, 1'b1);
        #100000;
        check("t7_fast_data", rx_data, 8'h11);
        check("t7_fast_done", done_cnt - d0, 1);
        rst = 1'b1;
        #200;
        rst = 1'b0;
        #20000;
        d0 = done_cnt;
        send_byte(8'h11, BIT_SLOW, 1'b1);
        #100000;
        check("t7_slow_data", rx_data, 8'h11);
        check("t7_slow_done", done_cnt - d0, 1);

        check("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
